// File: rtl/solution_writer.sv
// Solver solution stream to x/u result RAM writer (step-major addressing).
// Optional zero fill of unused horizon entries: define SOLUTION_WRITER_ZERO_FILL_EN.
module solution_writer #(
    parameter int STATE_DIM      = 12,
    parameter int INPUT_DIM      = 4,
    parameter int HORIZON        = 30,
    parameter int DATA_WIDTH     = 16,
    parameter int MEM_ADDR_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [31:0]               active_horizon,
    input  logic                      sol_valid,
    output logic                      sol_ready,
    input  logic                      sol_is_input,
    input  logic [DATA_WIDTH-1:0]     sol_data,
    output logic [MEM_ADDR_WIDTH-1:0] x_wraddress,
    output logic [DATA_WIDTH-1:0]     x_data_in,
    output logic                      x_wren,
    output logic [MEM_ADDR_WIDTH-1:0] u_wraddress,
    output logic [DATA_WIDTH-1:0]     u_data_in,
    output logic                      u_wren,
    output logic                      busy,
    output logic                      done,
    output logic                      tag_err
);
    localparam int MAX_DIM = (STATE_DIM > INPUT_DIM) ? STATE_DIM : INPUT_DIM;
    localparam int SW      = $clog2(HORIZON + 1);
    localparam int IW      = $clog2(MAX_DIM + 1);
    localparam int MAW     = MEM_ADDR_WIDTH;

`ifdef SOLUTION_WRITER_ZERO_FILL_EN
    typedef enum logic [2:0] {S_IDLE, S_X, S_U, S_FLUSH, S_ZFILL, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_X, S_U, S_FLUSH, S_DONE} state_t;
`endif

    state_t              r_state, w_next;
    logic [SW-1:0]       r_n, r_step, w_n_clamped;
    logic [IW-1:0]       r_index;
    logic                r_sol_ready, r_tag_err;
    logic                r_x_wren, r_u_wren;
    logic [MAW-1:0]      r_x_addr, r_u_addr;
    logic [DATA_WIDTH-1:0] r_x_data, r_u_data;

    logic w_in_x, w_in_u, w_accept, w_tag_ok, w_take, w_dim_last, w_phase_last;
    logic [MAW-1:0] w_x_addr, w_u_addr;

    assign w_in_x       = (r_state == S_X);
    assign w_in_u       = (r_state == S_U);
    // start takes priority: a beat offered alongside start is dropped.
    assign w_accept     = sol_valid & r_sol_ready & ~start;
    assign w_tag_ok     = w_in_u ? sol_is_input : ~sol_is_input;
    assign w_take       = w_accept & w_tag_ok;
    assign w_dim_last   = w_in_u ? (r_index == IW'(INPUT_DIM - 1)) : (r_index == IW'(STATE_DIM - 1));
    assign w_phase_last = w_dim_last & (w_in_u ? (r_step == r_n - SW'(2)) : (r_step == r_n - SW'(1)));
    assign w_x_addr     = MAW'(r_step) * MAW'(STATE_DIM) + MAW'(r_index);
    assign w_u_addr     = MAW'(r_step) * MAW'(INPUT_DIM) + MAW'(r_index);

    always_comb begin
        if (active_horizon == 32'd0)
            w_n_clamped = SW'(1);
        else if (active_horizon > 32'(HORIZON))
            w_n_clamped = SW'(HORIZON);
        else
            w_n_clamped = SW'(active_horizon);
    end

`ifdef SOLUTION_WRITER_ZERO_FILL_EN
    localparam int X_DEPTH = HORIZON * STATE_DIM;
    localparam int U_DEPTH = (HORIZON - 1) * INPUT_DIM;
    logic [MAW:0] r_zx, r_zu;
    logic w_in_zf, w_zx_go, w_zu_go, w_zf_last;
    assign w_in_zf   = (r_state == S_ZFILL);
    assign w_zx_go   = r_zx < (MAW+1)'(X_DEPTH);
    assign w_zu_go   = r_zu < (MAW+1)'(U_DEPTH);
    assign w_zf_last = (r_zx + (MAW+1)'(1) >= (MAW+1)'(X_DEPTH))
                     & (r_zu + (MAW+1)'(1) >= (MAW+1)'(U_DEPTH));

    // Fill writes come straight from the fill counters so done follows the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zx <= '0;
            r_zu <= '0;
        end else if (r_state == S_FLUSH) begin
            r_zx <= (MAW+1)'(r_n) * (MAW+1)'(STATE_DIM);
            r_zu <= (MAW+1)'(r_n - SW'(1)) * (MAW+1)'(INPUT_DIM);
        end else if (w_in_zf) begin
            if (w_zx_go) r_zx <= r_zx + (MAW+1)'(1);
            if (w_zu_go) r_zu <= r_zu + (MAW+1)'(1);
        end
    end

    assign x_wren      = r_x_wren | (w_in_zf & w_zx_go);
    assign u_wren      = r_u_wren | (w_in_zf & w_zu_go);
    assign x_wraddress = w_in_zf ? r_zx[MAW-1:0] : r_x_addr;
    assign u_wraddress = w_in_zf ? r_zu[MAW-1:0] : r_u_addr;
    assign x_data_in   = w_in_zf ? '0 : r_x_data;
    assign u_data_in   = w_in_zf ? '0 : r_u_data;
    assign busy        = w_in_x | w_in_u | (r_state == S_FLUSH) | w_in_zf;
`else
    assign x_wren      = r_x_wren;
    assign u_wren      = r_u_wren;
    assign x_wraddress = r_x_addr;
    assign u_wraddress = r_u_addr;
    assign x_data_in   = r_x_data;
    assign u_data_in   = r_u_data;
    assign busy        = w_in_x | w_in_u | (r_state == S_FLUSH);
`endif

    assign sol_ready = r_sol_ready;
    assign done      = (r_state == S_DONE);
    assign tag_err   = r_tag_err;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_X;
        end else begin
            case (r_state)
                S_X:     if (w_take && w_phase_last) w_next = (r_n > SW'(1)) ? S_U : S_FLUSH;
                S_U:     if (w_take && w_phase_last) w_next = S_FLUSH;
`ifdef SOLUTION_WRITER_ZERO_FILL_EN
                S_FLUSH: w_next = S_ZFILL;
                S_ZFILL: if (w_zf_last) w_next = S_DONE;
`else
                S_FLUSH: w_next = S_DONE;
`endif
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sol_ready <= 1'b0;
            r_n         <= SW'(1);
            r_step      <= '0;
            r_index     <= '0;
            r_tag_err   <= 1'b0;
            r_x_wren    <= 1'b0;
            r_u_wren    <= 1'b0;
            r_x_addr    <= '0;
            r_u_addr    <= '0;
            r_x_data    <= '0;
            r_u_data    <= '0;
        end else begin
            r_state     <= w_next;
            r_sol_ready <= (w_next == S_X) || (w_next == S_U);
            r_x_wren    <= w_take & w_in_x;
            r_u_wren    <= w_take & w_in_u;
            if (w_take && w_in_x) begin
                r_x_addr <= w_x_addr;
                r_x_data <= sol_data;
            end
            if (w_take && w_in_u) begin
                r_u_addr <= w_u_addr;
                r_u_data <= sol_data;
            end
            if (start) begin
                r_n       <= w_n_clamped;
                r_step    <= '0;
                r_index   <= '0;
                r_tag_err <= 1'b0;
            end else begin
                if (w_accept && !w_tag_ok)
                    r_tag_err <= 1'b1;
                if (w_take) begin
                    if (w_phase_last) begin
                        r_step  <= '0;
                        r_index <= '0;
                    end else if (w_dim_last) begin
                        r_step  <= r_step + SW'(1);
                        r_index <= '0;
                    end else begin
                        r_index <= r_index + IW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_solution_writer.sv
// Scoreboard bench for solution_writer: driver pushes expected RAM writes, monitor pops and compares.
module tb_solution_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] active_horizon;
    logic        sol_valid, sol_ready, sol_is_input;
    logic [15:0] sol_data;
    logic [8:0]  x_wraddress, u_wraddress;
    logic [15:0] x_data_in, u_data_in;
    logic        x_wren, u_wren, busy, done, tag_err;

    solution_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .active_horizon(active_horizon),
        .sol_valid(sol_valid), .sol_ready(sol_ready), .sol_is_input(sol_is_input),
        .sol_data(sol_data), .x_wraddress(x_wraddress), .x_data_in(x_data_in),
        .x_wren(x_wren), .u_wraddress(u_wraddress), .u_data_in(u_data_in),
        .u_wren(u_wren), .busy(busy), .done(done), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_x[$];
    wr_t exp_u[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  last_hs = 0;
    int  done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every RAM write must match the head of its queue, including its cycle.
    always @(negedge clk) begin
        wr_t e;
        if (x_wren === 1'b1) begin
            if (exp_x.size() == 0) begin
                tests++; fails++;
                $display("FAIL x_unexpected_write: addr %0d data %0h", x_wraddress, x_data_in);
            end else begin
                e = exp_x.pop_front();
                check("x_addr", 32'(x_wraddress), 32'(e.addr));
                check("x_data", 32'(x_data_in), 32'(e.data));
                check("x_cycle", cyc, e.cyc);
            end
        end
        if (u_wren === 1'b1) begin
            if (exp_u.size() == 0) begin
                tests++; fails++;
                $display("FAIL u_unexpected_write: addr %0d data %0h", u_wraddress, u_data_in);
            end else begin
                e = exp_u.pop_front();
                check("u_addr", 32'(u_wraddress), 32'(e.addr));
                check("u_data", 32'(u_data_in), 32'(e.data));
                check("u_cycle", cyc, e.cyc);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    // Offer one beat; on handshake push its expected write (if it should be written).
    task automatic send_beat(input bit tag, input logic [15:0] d, input bit push_ok,
                             input logic [8:0] addr, input int gap);
        bit  got = 1'b0;
        wr_t e;
        repeat (gap) begin @(posedge clk); #1; end
        sol_valid    = 1'b1;
        sol_is_input = tag;
        sol_data     = d;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (sol_ready === 1'b1) begin
                got     = 1'b1;
                last_hs = cyc;
                if (push_ok) begin
                    e.addr = addr; e.data = d; e.cyc = cyc + 1;
                    if (tag) exp_u.push_back(e); else exp_x.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        sol_valid = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL handshake_timeout: beat data %0h never accepted", d);
        end
    endtask

    task automatic do_start(input logic [31:0] ah);
        start = 1'b1;
        active_horizon = ah;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic stream(input int n, input bit rnd);
        for (int k = 0; k < n * 12; k++)
            send_beat(1'b0, 16'(k), 1'b1, 9'(k), rnd ? int'($urandom_range(0, 2)) : 0);
        for (int k = 0; k < (n - 1) * 4; k++)
            send_beat(1'b1, 16'(k), 1'b1, 9'(k), rnd ? int'($urandom_range(0, 2)) : 0);
    endtask

    // done must appear two cycles after the final handshake (FLUSH, then DONE) for one cycle.
    task automatic wait_done(input string name);
        bit found = 1'b0;
        int seen  = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin found = 1'b1; seen = cyc; end
        end
        check({name, "_done_seen"}, 32'(found), 32'd1);
        if (found) check({name, "_done_latency"}, seen - last_hs, 32'd2);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_busy_idle"}, 32'(busy), 32'd0);
        check({name, "_ready_idle"}, 32'(sol_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; active_horizon = 32'd0;
        sol_valid = 1'b0; sol_is_input = 1'b0; sol_data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(sol_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tag_err", 32'(tag_err), 32'd0);
        check("rst_x_wren", 32'(x_wren), 32'd0);
        check("rst_u_wren", 32'(u_wren), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full horizon, then N=1, then clamping of 0 and 50.
        do_start(32'd30);
        stream(30, 1'b0);
        wait_done("full");
        check("full_tag_err", 32'(tag_err), 32'd0);

        do_start(32'd1);
        stream(1, 1'b0);
        wait_done("n1");

        do_start(32'd0);
        stream(1, 1'b0);
        wait_done("clamp0");

        do_start(32'd50);
        stream(30, 1'b0);
        wait_done("clamp50");

        // Tag error at x beat 5: consumed, not written, sticky; resend completes.
        do_start(32'd2);
        for (int k = 0; k < 5; k++) send_beat(1'b0, 16'(k), 1'b1, 9'(k), 0);
        send_beat(1'b1, 16'hBAD0, 1'b0, 9'd0, 0);
        check("tag_err_set", 32'(tag_err), 32'd1);
        for (int k = 5; k < 24; k++) send_beat(1'b0, 16'(k), 1'b1, 9'(k), 0);
        for (int k = 0; k < 4; k++) send_beat(1'b1, 16'(k), 1'b1, 9'(k), 0);
        wait_done("tagerr");
        check("tag_err_held", 32'(tag_err), 32'd1);

        // Abort after 100 x beats; restart coincides with a beat, which must be dropped.
        d0 = done_cnt;
        do_start(32'd30);
        check("tag_err_cleared", 32'(tag_err), 32'd0);
        for (int k = 0; k < 100; k++) send_beat(1'b0, 16'(k + 1000), 1'b1, 9'(k), 0);
        sol_valid = 1'b1; sol_is_input = 1'b0; sol_data = 16'hDEAD;
        start = 1'b1; active_horizon = 32'd30;
        @(posedge clk); #1;
        start = 1'b0; sol_valid = 1'b0;
        stream(30, 1'b0);
        wait_done("abort");
        check("abort_single_done", done_cnt - d0, 32'd1);

        // Backpressure with N=3.
        do_start(32'd3);
        stream(3, 1'b1);
        wait_done("bp");

        // Reset in the middle of U_PHASE.
        do_start(32'd3);
        for (int k = 0; k < 36; k++) send_beat(1'b0, 16'(k), 1'b1, 9'(k), int'($urandom_range(0, 2)));
        for (int k = 0; k < 5; k++) send_beat(1'b1, 16'(k), 1'b1, 9'(k), int'($urandom_range(0, 2)));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(sol_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_u_addr", 32'(u_wraddress), 32'd0);
        check("mid_rst_x_addr", 32'(x_wraddress), 32'd0);
        check("mid_rst_u_data", 32'(u_data_in), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_start(32'd1);
        stream(1, 1'b0);
        wait_done("post_rst");

        check("sb_x_drained", exp_x.size(), 32'd0);
        check("sb_u_drained", exp_u.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/solution_writer.md
Name: solution_writer

Overview:
Downstream of the ADMM solver core, upstream of the host register interface's x/u result RAM read path. Accepts the solver's per-iteration solution stream (state trajectory, then input trajectory), one element per beat over a valid/ready handshake. Writes each element into the x or u result RAM at the step-major address the host read decoder uses: step*DIM + index. Reports busy, done and protocol-error status to the control logic.

Parameters:
STATE_DIM, 12, state vector length (x elements per step)
INPUT_DIM, 4, input vector length (u elements per step)
HORIZON, 30, maximum horizon; x RAM holds HORIZON steps, u RAM holds HORIZON-1 steps
DATA_WIDTH, 16, fixed-point element width
MEM_ADDR_WIDTH, 9, result RAM address width; must hold HORIZON*STATE_DIM-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begin capturing a new solution
active_horizon  in  32  horizon N for this solve; sampled on start
sol_valid  in  1  solver element valid
sol_ready  out  1  writer can accept an element
sol_is_input  in  1  tag: 0 = x element, 1 = u element
sol_data  in  DATA_WIDTH  element value
x_wraddress  out  MEM_ADDR_WIDTH  x result RAM write address
x_data_in  out  DATA_WIDTH  x result RAM write data
x_wren  out  1  x result RAM write enable
u_wraddress  out  MEM_ADDR_WIDTH  u result RAM write address
u_data_in  out  DATA_WIDTH  u result RAM write data
u_wren  out  1  u result RAM write enable
busy  out  1  high from start until the final write is issued
done  out  1  one-cycle pulse once all writes are complete
tag_err  out  1  sticky; a beat arrived with a tag that does not match the current phase

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; step and index counters 0; latched N = 1.
- Handshake: an element transfers on a cycle with sol_valid & sol_ready. sol_ready is a registered state decode: 1 only in X_PHASE and U_PHASE.
- On start, sample N = active_horizon, clamped to the range 1..HORIZON: 0 becomes 1; values above HORIZON become HORIZON.
- FSM:
  - IDLE -> X_PHASE on start; clear counters and tag_err.
  - X_PHASE: each accepted beat increments index; at index == STATE_DIM-1, index wraps to 0 and step increments. After the N*STATE_DIM-th beat: go to U_PHASE if N > 1, else go to FLUSH.
  - U_PHASE: same counting with INPUT_DIM. After the (N-1)*INPUT_DIM-th beat, go to FLUSH.
  - FLUSH: one cycle; the last write retires. Then DONE.
  - DONE: done=1 for exactly one cycle; then IDLE.
- Write latency: one cycle. A beat accepted in cycle t drives *_wren=1 in cycle t+1, with address step*DIM + index captured at t. Address arithmetic is computed at MEM_ADDR_WIDTH with no truncation (max 359 at default parameters).
- Tag mismatch (sol_is_input != 0 in X_PHASE, or != 1 in U_PHASE):
  - the beat is consumed (handshake completes) but not written;
  - counters do not advance;
  - tag_err is set and stays high until the next start.
- busy = 1 in X_PHASE, U_PHASE and FLUSH; 0 in IDLE and DONE.
- start during any non-IDLE state aborts the capture:
  - counters clear and N is re-sampled;
  - the FSM goes to X_PHASE next cycle;
  - a write already registered still retires;
  - no done pulse for the aborted capture.
- start in the same cycle as an accepted beat: start wins; the beat is dropped.
- sol_valid in IDLE, FLUSH or DONE is ignored (sol_ready=0).
- Reset mid-operation: immediate return to the IDLE reset state; RAM contents are not cleared.

Optional Feature:
SOLUTION_WRITER_ZERO_FILL_EN:
- Defined: FLUSH is followed by ZERO_FILL (sol_ready=0, busy=1). ZERO_FILL writes 0 to x addresses N*STATE_DIM .. HORIZON*STATE_DIM-1 and u addresses (N-1)*INPUT_DIM .. (HORIZON-1)*INPUT_DIM-1, one write per RAM per cycle with x and u filling in parallel. It then goes to DONE.
- Undefined: no ZERO_FILL state; entries beyond N keep their previous contents.

Test Plan:
- Full horizon: start with N=30; stream 360 x beats then 116 u beats with data = beat number → x RAM addr k holds k; u RAM addr k holds k; done pulses one cycle after FLUSH; tag_err=0.
- N=1: stream 12 x beats → X_PHASE goes directly to FLUSH; no u_wren asserted; done pulse.
- Clamping: active_horizon=0 → 12 x beats, same as N=1. active_horizon=50 → behaves as N=30 (360 x / 116 u beats).
- Tag error: N=2, inject sol_is_input=1 at x beat 5 → beat not written, tag_err=1 and held; a correct resend completes the capture; done still pulses.
- Abort: N=30, start pulse after 100 x beats → next write lands at x addr 0; exactly one done, at the end of the restarted capture.
- Backpressure/reset: toggle sol_valid randomly, N=3 → 36 x writes and 8 u writes in order, each one cycle after its handshake. Assert rst_n=0 mid U_PHASE → all outputs 0 immediately.
